// File: rtl/dds_panel_ctrl_if.sv
// Front-panel request/configuration bundle between the button conditioning
// logic, the panel controller and the DDS core.
interface dds_panel_ctrl_if;
    logic        iBtnWave;
    logic        iBtnStep;
    logic        iBtnUp;
    logic        iBtnDown;
    logic        iUpHeld;
    logic        iDownHeld;
    logic        iCfgReady;
    logic        oCfgValid;
    logic [1:0]  oWaveSel;
    logic [31:0] oTuneWord;
    logic [2:0]  oStepIdx;

    modport master (
        output iBtnWave, iBtnStep, iBtnUp, iBtnDown, iUpHeld, iDownHeld, iCfgReady,
        input  oCfgValid, oWaveSel, oTuneWord, oStepIdx
    );

    modport slave (
        input  iBtnWave, iBtnStep, iBtnUp, iBtnDown, iUpHeld, iDownHeld, iCfgReady,
        output oCfgValid, oWaveSel, oTuneWord, oStepIdx
    );
endinterface

// File: rtl/dds_panel_ctrl.sv
// DDS front-panel controller: arbitrates button pulses into waveform/step/tuning
// updates delivered over valid/ready. Define PANEL_AUTOREPEAT_EN for held-button repeat.
module dds_panel_ctrl #(
    parameter logic [31:0] FTW_RESET    = 32'd42950,
    parameter logic [31:0] FTW_MIN      = 32'd43,
    parameter logic [31:0] FTW_MAX      = 32'd858993459,
    parameter logic [31:0] FTW_STEP0    = 32'd43,
    parameter int          STEP_SHIFT   = 3,
    parameter int          STEP_MAX     = 5,
    parameter int          REPEAT_DELAY = 50000000,
    parameter int          REPEAT_RATE  = 10000000
) (
    input logic             CLK,
    input logic             RESET,
    dds_panel_ctrl_if.slave bus
);

    typedef enum logic { IDLE, LOAD } state_e;

    // Pending-request bit positions
    localparam int P_WAVE = 0;
    localparam int P_STEP = 1;
    localparam int P_UP   = 2;
    localparam int P_DOWN = 3;

    state_e      state_q, state_d;
    logic [3:0]  pend_q, pend_d;
    logic [3:0]  req_set, req_clr;
    logic [1:0]  wave_q, wave_d;
    logic [31:0] ftw_q, ftw_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shamt;
    logic [31:0] step_val, head_up, head_dn;
    logic [1:0]  rep_fire;   // [0] up, [1] down

    assign shamt    = 8'(STEP_SHIFT) * {5'd0, idx_q};
    assign step_val = FTW_STEP0 << shamt;
    assign head_up  = FTW_MAX - ftw_q;
    assign head_dn  = ftw_q - FTW_MIN;

`ifdef PANEL_AUTOREPEAT_EN
    logic [1:0]       held;
    logic [1:0][31:0] rep_cnt_q, rep_cnt_d;
    logic [1:0]       rep_arm_q, rep_arm_d;
    logic [1:0][31:0] rep_inc;

    // Pressing both directions at once suppresses repeat entirely
    assign held = {bus.iDownHeld, bus.iUpHeld} & ~{2{bus.iUpHeld & bus.iDownHeld}};

    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_arm_d = rep_arm_q;
        rep_fire  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            rep_inc[i] = rep_cnt_q[i] + 32'd1;
            if (!held[i]) begin
                rep_cnt_d[i] = '0;
                rep_arm_d[i] = 1'b0;
            end else if (rep_inc[i] == (rep_arm_q[i] ? 32'(REPEAT_RATE) : 32'(REPEAT_DELAY))) begin
                rep_fire[i]  = 1'b1;
                rep_cnt_d[i] = '0;
                rep_arm_d[i] = 1'b1;
            end else begin
                rep_cnt_d[i] = rep_inc[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rep_cnt_q <= '0;
            rep_arm_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_arm_q <= rep_arm_d;
        end
    end
`else
    assign rep_fire = 2'b00;
`endif

    assign req_set = {bus.iBtnDown | rep_fire[1], bus.iBtnUp | rep_fire[0],
                      bus.iBtnStep, bus.iBtnWave};

    always_comb begin
        state_d = state_q;
        wave_d  = wave_q;
        ftw_d   = ftw_q;
        idx_d   = idx_q;
        req_clr = '0;
        case (state_q)
            IDLE: begin
                if (pend_q[P_WAVE]) begin
                    req_clr[P_WAVE] = 1'b1;
                    wave_d          = wave_q + 2'd1;
                    state_d         = LOAD;
                end else if (pend_q[P_STEP]) begin
                    req_clr[P_STEP] = 1'b1;
                    idx_d           = (idx_q == 3'(STEP_MAX)) ? 3'd0 : idx_q + 3'd1;
                    state_d         = LOAD;
                end else if (pend_q[P_UP] && pend_q[P_DOWN]) begin
                    // Opposing requests cancel without a transaction
                    req_clr[P_UP]   = 1'b1;
                    req_clr[P_DOWN] = 1'b1;
                end else if (pend_q[P_UP]) begin
                    req_clr[P_UP] = 1'b1;
                    ftw_d         = (head_up < step_val) ? FTW_MAX : ftw_q + step_val;
                    state_d       = LOAD;
                end else if (pend_q[P_DOWN]) begin
                    req_clr[P_DOWN] = 1'b1;
                    ftw_d           = (head_dn < step_val) ? FTW_MIN : ftw_q - step_val;
                    state_d         = LOAD;
                end
            end
            LOAD: begin
                if (bus.iCfgReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A pulse landing on the servicing edge survives the clear
        pend_d = (pend_q & ~req_clr) | req_set;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            pend_q  <= '0;
            wave_q  <= '0;
            ftw_q   <= FTW_RESET;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            wave_q  <= wave_d;
            ftw_q   <= ftw_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.oCfgValid = (state_q == LOAD);
    assign bus.oWaveSel  = wave_q;
    assign bus.oTuneWord = ftw_q;
    assign bus.oStepIdx  = idx_q;

endmodule

// File: tb/tb_dds_panel_ctrl.sv
// Scoreboard bench for dds_panel_ctrl: a request-level reference model predicts
// each configuration transaction; a negedge monitor checks what the DUT presents.
module tb_dds_panel_ctrl;

    localparam longint FTW_RESET = 42950;
    localparam longint FTW_MIN   = 43;
    localparam longint FTW_MAX   = 858993459;
    localparam longint STEP0     = 43;
    localparam int     SHIFT     = 3;
    localparam int     SMAX      = 5;
    localparam int     REP_D     = 8;
    localparam int     REP_R     = 4;

    typedef struct {
        int unsigned cyc;
        int          wave;
        longint      ftw;
        int          idx;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    dds_panel_ctrl_if bus();

    dds_panel_ctrl #(.REPEAT_DELAY(REP_D), .REPEAT_RATE(REP_R)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int unsigned edge_cnt = 0;
    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    endtask

    // ---------------- reference model ----------------
    bit     m_pend[4];   // wave, step, up, down
    bit     m_busy, m_busy_now;
    int     m_wave, m_idx, run_u, run_d;
    longint m_ftw;
    exp_t   q[$];
    logic   u_held = 0, d_held = 0;

    function automatic bit rep_fires(input int run);
        return (run == REP_D) || (run > REP_D && ((run - REP_D) % REP_R) == 0);
    endfunction

    task automatic push_exp();
        exp_t e;
        m_busy = 1;
        e.cyc = edge_cnt + 1; e.wave = m_wave; e.ftw = m_ftw; e.idx = m_idx;
        q.push_back(e);
    endtask

    // Effect of the coming clock edge, given the inputs just driven
    task automatic model_step(input bit w, s, u, d, rdy, rst);
        bit     fu, fd;
        bit     pn[4];
        longint stp;
        m_busy_now = m_busy;
        if (rst) begin
            m_pend = '{default: 0};
            m_busy = 0; m_wave = 0; m_idx = 0; m_ftw = FTW_RESET;
            run_u = 0; run_d = 0;
            q.delete();
            return;
        end
        fu = 0; fd = 0;
`ifdef PANEL_AUTOREPEAT_EN
        run_u = (u_held && !d_held) ? run_u + 1 : 0;
        run_d = (d_held && !u_held) ? run_d + 1 : 0;
        fu = rep_fires(run_u);
        fd = rep_fires(run_d);
`endif
        pn = '{w, s, u | fu, d | fd};
        stp = STEP0 << (SHIFT * m_idx);
        if (m_busy) begin
            if (rdy) m_busy = 0;
        end else if (m_pend[0]) begin
            m_pend[0] = 0; m_wave = (m_wave + 1) % 4; push_exp();
        end else if (m_pend[1]) begin
            m_pend[1] = 0; m_idx = (m_idx == SMAX) ? 0 : m_idx + 1; push_exp();
        end else if (m_pend[2] && m_pend[3]) begin
            m_pend[2] = 0; m_pend[3] = 0;
        end else if (m_pend[2]) begin
            m_pend[2] = 0; m_ftw = (m_ftw + stp > FTW_MAX) ? FTW_MAX : m_ftw + stp; push_exp();
        end else if (m_pend[3]) begin
            m_pend[3] = 0; m_ftw = (m_ftw - stp < FTW_MIN) ? FTW_MIN : m_ftw - stp; push_exp();
        end
        for (int i = 0; i < 4; i++) m_pend[i] = m_pend[i] | pn[i];
    endtask

    task automatic drive(input bit w, s, u, d, rdy, input bit rst = 0);
        @(posedge CLK);
        #1;
        RESET          = rst;
        bus.iBtnWave   = w;
        bus.iBtnStep   = s;
        bus.iBtnUp     = u;
        bus.iBtnDown   = d;
        bus.iCfgReady  = rdy;
        bus.iUpHeld    = u_held;
        bus.iDownHeld  = d_held;
        model_step(w, s, u, d, rdy, rst);
    endtask

    // One pulse followed by enough idle cycles for the handshake to finish
    task automatic press(input bit w, s, u, d);
        drive(w, s, u, d, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, bus.oCfgValid, 0);
        check({tag, "_wave"},  bus.oWaveSel, 0);
        check({tag, "_ftw"},   bus.oTuneWord, FTW_RESET);
        check({tag, "_idx"},   bus.oStepIdx, 0);
    endtask

    // ---------------- monitor ----------------
    logic prev_v = 0;
    exp_t cur, hold_e;
    always @(negedge CLK) begin
        if (RESET !== 1'b1 || bus.oCfgValid === 1'b1) begin
            check("valid_level", bus.oCfgValid, m_busy_now);
            if (bus.oCfgValid && !prev_v) begin
                if (q.size() == 0) begin
                    check("unexpected_txn", 1, 0);
                end else begin
                    cur = q.pop_front();
                    check("txn_cycle", edge_cnt, cur.cyc);
                    check("txn_wave", bus.oWaveSel, cur.wave);
                    check("txn_ftw", bus.oTuneWord, cur.ftw);
                    check("txn_idx", bus.oStepIdx, cur.idx);
                    hold_e <= cur;
                end
            end else if (bus.oCfgValid) begin
                check("hold_wave", bus.oWaveSel, hold_e.wave);
                check("hold_ftw", bus.oTuneWord, hold_e.ftw);
                check("hold_idx", bus.oStepIdx, hold_e.idx);
            end else if (q.size() > 0 && edge_cnt >= q[0].cyc) begin
                check("missed_txn", 0, 1);
                void'(q.pop_front());
            end
        end
        prev_v <= bus.oCfgValid;
    end

    // ---------------- stimulus ----------------
    initial begin
        int waited;
        RESET = 1;
        bus.iBtnWave = 0; bus.iBtnStep = 0; bus.iBtnUp = 0; bus.iBtnDown = 0;
        bus.iUpHeld = 0; bus.iDownHeld = 0; bus.iCfgReady = 0;

        repeat (3) drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        @(negedge CLK);
        check_reset_outputs("reset");

        // Single up: 42950 + 43
        press(0, 0, 1, 0);
        drive(0, 0, 0, 0, 1);
        // Step, step, up: step 43<<6 = 2752
        press(0, 1, 0, 0);
        press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        // Wave+Up+Down together: one transaction, up/down cancel
        press(1, 0, 1, 1);
        press(0, 0, 0, 0);
        // Ready withheld: config must hold, second up queued behind it
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        repeat (8) drive(0, 0, 0, 0, 0);
        repeat (6) drive(0, 0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 15) == 0) u_held = ~u_held;
            if ($urandom_range(0, 15) == 0) d_held = ~d_held;
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 1) == 1);
        end
        u_held = 0; d_held = 0;
        repeat (6) drive(0, 0, 0, 0, 1);

        // Saturation: largest step, floor then ceiling
        for (int i = 0; i < 8 && m_idx != SMAX; i++) press(0, 1, 0, 0);
        check("reached_step_max", m_idx, SMAX);
        repeat (3) press(0, 0, 0, 1);
        for (int i = 0; i < 620; i++) press(0, 0, 1, 0);
        check("model_at_max", m_ftw, FTW_MAX);
        press(0, 1, 0, 0);   // STEP_MAX wraps to 0

        // Held-up level for 20 cycles (repeats only when the feature is built)
        u_held = 1;
        repeat (20) drive(0, 0, 0, 0, 1);
        u_held = 0;
        repeat (8) drive(0, 0, 0, 0, 1);

        // Reset in the middle of a stalled handshake
        drive(1, 0, 0, 0, 0);
        waited = 0;
        while (bus.oCfgValid !== 1'b1 && waited < 10) begin
            drive(0, 0, 0, 0, 0);
            waited++;
        end
        check("load_reached", bus.oCfgValid, 1);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        @(negedge CLK);
        check_reset_outputs("midload_reset");

        press(0, 0, 0, 1);
        repeat (10) drive(0, 0, 0, 0, 1);
        check("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dds_panel_ctrl.md
# dds_panel_ctrl

Front-panel controller for the DDS function generator. Takes the single-cycle pulses produced by the per-button edge detectors and arbitrates them into configuration updates for the DDS core:
- waveform select
- frequency tuning word with saturating up/down steps
- selectable step size

It delivers each update over a valid/ready handshake. It sits between the button conditioning blocks and the phase-accumulator/waveform datapath.

## Interface
- FTW_RESET, 32'd42950, tuning word after reset (about 1 kHz at 100 MHz)
- FTW_MIN, 32'd43, lower saturation bound
- FTW_MAX, 32'd858993459, upper saturation bound
- FTW_STEP0, 32'd43, step at index 0
- STEP_SHIFT, 3, left-shift per step index
- STEP_MAX, 5, highest step index; `FTW_STEP0 << (STEP_SHIFT*STEP_MAX)` must fit in 32 bits
- REPEAT_DELAY, 50000000, hold cycles before the first auto-repeat
- REPEAT_RATE, 10000000, cycles between subsequent repeats
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- iBtnWave  in  1  pulse: next waveform
- iBtnStep  in  1  pulse: next step index
- iBtnUp  in  1  pulse: frequency up
- iBtnDown  in  1  pulse: frequency down
- iUpHeld  in  1  level: up button held (auto-repeat only)
- iDownHeld  in  1  level: down button held (auto-repeat only)
- iCfgReady  in  1  DDS core accepts configuration
- oCfgValid  out  1  configuration presented
- oWaveSel  out  2  0 sine, 1 square, 2 triangle, 3 sawtooth
- oTuneWord  out  32  frequency tuning word
- oStepIdx  out  3  current step index

## Operation
- Pending register: one bit per request (Wave, Step, Up, Down).
  - Each input pulse sets its bit on the clock edge where it is high.
  - A pulse on an already-pending bit merges; it is not counted.
- FSM has two states, IDLE and LOAD.
- IDLE with any bit pending: service exactly one request, in priority order Wave > Step > Up/Down.
  - Clear its bit, update the config registers, go to LOAD on the same edge.
- Up and Down both pending when serviced: clear both, no update, stay IDLE.
- Wave: oWaveSel increments, 3 wraps to 0.
- Step: oStepIdx increments; STEP_MAX wraps to 0.
- Step value is `FTW_STEP0 << (STEP_SHIFT*oStepIdx)`, 32-bit.
- Up: if `FTW_MAX - oTuneWord < step`, set FTW_MAX; otherwise add step.
- Down: if `oTuneWord - FTW_MIN < step`, set FTW_MIN; otherwise subtract step. No wrap-around in either direction.
- LOAD: oCfgValid=1. All config outputs are held stable until an edge with iCfgReady=1, then return to IDLE.
- Requests arriving during LOAD set pending bits and are serviced after return to IDLE.
- Reset (any state, mid-handshake included), applied on the next edge:
  - state IDLE, pending cleared
  - oCfgValid=0, oWaveSel=0, oTuneWord=FTW_RESET, oStepIdx=0
  - repeat counters cleared

## Timing
- Pulse high in cycle k → pending bit visible in k+1 → config updated and oCfgValid=1 in k+2.
- Latency is 2 cycles when IDLE with nothing else pending.
- Handshake completes on an edge with oCfgValid&iCfgReady.
- Minimum spacing between transactions is 2 cycles: one LOAD cycle plus one IDLE cycle.
- iCfgReady is ignored in IDLE.
- Pulses in the same cycle as the servicing edge are retained.

## Configuration
- PANEL_AUTOREPEAT_EN defined: while iUpHeld (or iDownHeld) is continuously high, a counter runs.
  - After REPEAT_DELAY cycles it sets the Up (Down) pending bit.
  - It then sets the bit again every REPEAT_RATE cycles.
  - The counter clears when the level drops.
  - Both levels high: neither counter runs.
- Undefined: iUpHeld/iDownHeld are ignored and no repeat counters are synthesized. Only pulse inputs generate requests.

## Test plan
- Reset, one iBtnUp pulse, iCfgReady=1 → oCfgValid high one cycle, 2 cycles after the pulse; oTuneWord=42993.
- Two iBtnStep pulses then iBtnUp → oStepIdx=2, step 2752, oTuneWord=45702; 3 handshakes.
- FTW_RESET=100, two iBtnDown pulses → 57, then saturate at 43. A third Down → stays 43, handshake still occurs.
- iBtnWave, iBtnUp, iBtnDown in the same cycle → one transaction, oWaveSel=1, oTuneWord unchanged.
- iCfgReady low for 10 cycles, iBtnUp pulse during LOAD → first config held stable throughout; second transaction gives 43036 after the release.
- Macro defined, REPEAT_DELAY=8, REPEAT_RATE=4, iUpHeld high for 20 cycles → 4 Up transactions. RESET asserted mid-LOAD → outputs return to reset values next cycle.
